// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_if
// Description : Bundle of the fetch-side lookup, execute-side training and
//               statistics signals for branch_predictor. The master is the
//               pipeline (fetch + execute) and the slave is the predictor.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_predictor_if #(
  parameter int DATA_WIDTH = 32
);
  // Fetch-stage lookup
  logic [DATA_WIDTH-1:0] pc_fetch;
  logic                  predict_valid;
  logic                  predict_taken;
  logic [DATA_WIDTH-1:0] predict_target;

  // Execute-stage training
  logic                  update_en;
  logic [DATA_WIDTH-1:0] update_pc;
  logic                  update_taken;
  logic [DATA_WIDTH-1:0] update_target;
  logic                  update_mispredict;

  // Statistics (zero when the statistics build option is off)
  logic [31:0]           stat_branches;
  logic [31:0]           stat_mispredicts;

  modport master (
    output pc_fetch,
    output update_en, update_pc, update_taken, update_target, update_mispredict,
    input  predict_valid, predict_taken, predict_target,
    input  stat_branches, stat_mispredicts
  );

  modport slave (
    input  pc_fetch,
    input  update_en, update_pc, update_taken, update_target, update_mispredict,
    output predict_valid, predict_taken, predict_target,
    output stat_branches, stat_mispredicts
  );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped branch target buffer with 2-bit saturating
//               direction counters. Lookup is combinational from registered
//               table state; training from resolved branches is sequential.
//               Build option BP_STATS_EN adds resolved-branch and mispredict
//               counters; without it the statistics outputs are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
  parameter int DATA_WIDTH  = 32,
  parameter int BTB_ENTRIES = 16
) (
  input  wire               clk,
  input  wire               rst,
  branch_predictor_if.slave bp
);

  // Derived geometry: word-aligned PCs, so bits [1:0] never take part.
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

  // Counter encodings
  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_WEAK_T    = 2'b10;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  // --------------------------------------------------------------------------
  // Table state
  // --------------------------------------------------------------------------
  logic [BTB_ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_d    [BTB_ENTRIES];
  logic [DATA_WIDTH-1:0]  target_q [BTB_ENTRIES];
  logic [DATA_WIDTH-1:0]  target_d [BTB_ENTRIES];
  logic [1:0]             ctr_q    [BTB_ENTRIES];
  logic [1:0]             ctr_d    [BTB_ENTRIES];

  // --------------------------------------------------------------------------
  // Address split for both ports
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;

  assign fetch_idx = bp.pc_fetch[IDX_W+1:2];
  assign fetch_tag = bp.pc_fetch[DATA_WIDTH-1:IDX_W+2];
  assign upd_idx   = bp.update_pc[IDX_W+1:2];
  assign upd_tag   = bp.update_pc[DATA_WIDTH-1:IDX_W+2];

  // The byte-offset bits are deliberately ignored by both ports.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.pc_fetch[1:0], bp.update_pc[1:0]};

  // --------------------------------------------------------------------------
  // Lookup
  // --------------------------------------------------------------------------
  logic fetch_hit;

  // Lookup reads registered state only, so a same-cycle update to the same
  // entry is not forwarded: the new contents appear the following cycle.
  always_comb begin
    fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  end

  assign bp.predict_valid  = fetch_hit;
  assign bp.predict_taken  = fetch_hit && ctr_q[fetch_idx][1];
  assign bp.predict_target = fetch_hit ? target_q[fetch_idx] : '0;

  // --------------------------------------------------------------------------
  // Training
  // --------------------------------------------------------------------------
  logic upd_hit;

  // Next-state for the addressed entry; every other entry holds its value.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    if (bp.update_en) begin
      if (upd_hit) begin
        if (bp.update_taken) begin
          // Saturate at strongly-taken; the target may have moved
          // (indirect jumps), so always refresh it on a taken outcome.
          if (ctr_q[upd_idx] != CTR_STRONG_T) begin
            ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
          end
          target_d[upd_idx] = bp.update_target;
        end else begin
          // Saturate at strongly-not-taken; target is kept for reuse.
          if (ctr_q[upd_idx] != CTR_STRONG_NT) begin
            ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
          end
        end
      end else if (bp.update_taken) begin
        // Allocate (or evict a conflicting entry) only for taken branches;
        // a not-taken miss carries no useful target and would only thrash.
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = bp.update_target;
        ctr_d[upd_idx]    = CTR_WEAK_T;
      end
    end
  end

  // Table registers; reset wins over a simultaneous update.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WEAK_NT;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
`ifdef BP_STATS_EN
  logic [31:0] stat_branches_q,    stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  // Free-running wrapping event counters.
  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (bp.update_en) begin
      stat_branches_d = stat_branches_q + 32'd1;
      if (bp.update_mispredict) begin
        stat_mispredicts_d = stat_mispredicts_q + 32'd1;
      end
    end
  end

  // Counter registers; results show up the cycle after the event.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign bp.stat_branches    = stat_branches_q;
  assign bp.stat_mispredicts = stat_mispredicts_q;
`else
  assign bp.stat_branches    = '0;
  assign bp.stat_mispredicts = '0;

  // Mispredict flag only feeds the statistics counters.
  logic unused_mispredict;
  assign unused_mispredict = bp.update_mispredict;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Directed self-checking bench for branch_predictor
//               (16 entries, 32-bit addresses).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

  localparam int DW = 32;

`ifdef BP_STATS_EN
  localparam logic [31:0] EXP_BRANCHES    = 32'd5;
  localparam logic [31:0] EXP_MISPREDICTS = 32'd2;
`else
  localparam logic [31:0] EXP_BRANCHES    = 32'd0;
  localparam logic [31:0] EXP_MISPREDICTS = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  branch_predictor_if #(.DATA_WIDTH(DW)) bp_if ();

  branch_predictor #(
    .DATA_WIDTH (DW),
    .BTB_ENTRIES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bp (bp_if.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a fetch PC and check all three prediction outputs (takes #1).
  task automatic look(input string tag, input logic [31:0] pc,
                      input logic v, input logic t, input logic [31:0] tgt);
    bp_if.pc_fetch = pc;
    #1;
    chk({tag, ".valid"},  {31'b0, bp_if.predict_valid}, {31'b0, v});
    chk({tag, ".taken"},  {31'b0, bp_if.predict_taken}, {31'b0, t});
    chk({tag, ".target"}, bp_if.predict_target, tgt);
  endtask

  task automatic upd(input logic en, input logic [31:0] pc, input logic tk,
                     input logic [31:0] tgt, input logic mis);
    bp_if.update_en         = en;
    bp_if.update_pc         = pc;
    bp_if.update_taken      = tk;
    bp_if.update_target     = tgt;
    bp_if.update_mispredict = mis;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One training step on 0x40 followed by a lookup of the result.
  task automatic train(input string tag, input logic tk, input logic [31:0] tgt,
                       input logic exp_taken);
    upd(1'b1, 32'h40, tk, tgt, 1'b0);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    look(tag, 32'h40, 1'b1, exp_taken, 32'h100);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    rst = 1'b1;
    bp_if.pc_fetch = '0;
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    look("rst_0x40", 32'h40, 1'b0, 1'b0, 32'h0);
    look("rst_0x80", 32'h80, 1'b0, 1'b0, 32'h0);
    chk("rst_stat_br", bp_if.stat_branches, 32'h0);
    chk("rst_stat_mp", bp_if.stat_mispredicts, 32'h0);

    // Allocation: invisible in the update cycle, hit (weakly taken) after.
    upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
    look("alloc_pre", 32'h40, 1'b0, 1'b0, 32'h0);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    look("alloc_post", 32'h40, 1'b1, 1'b1, 32'h100);

    // Counter walk from 2: down to 0 and hold, then up to 3 and hold.
    // Not-taken updates carry a bogus target that must not be stored.
    train("nt_c1",   1'b0, 32'hDEAD, 1'b0);
    train("nt_c0",   1'b0, 32'hDEAD, 1'b0);
    train("nt_hold", 1'b0, 32'hDEAD, 1'b0);
    train("t_c1",    1'b1, 32'h100,  1'b0);
    train("t_c2",    1'b1, 32'h100,  1'b1);
    train("t_c3",    1'b1, 32'h100,  1'b1);
    train("t_hold1", 1'b1, 32'h100,  1'b1);
    train("t_hold2", 1'b1, 32'h100,  1'b1);
    train("nt_c2",   1'b0, 32'hDEAD, 1'b1);
    train("nt_c1b",  1'b0, 32'hDEAD, 1'b0);

    // Alias at index 0 with a different tag.
    look("alias_miss", 32'h80, 1'b0, 1'b0, 32'h0);
    upd(1'b1, 32'h80, 1'b0, 32'h999, 1'b0);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    look("alias_nt_80", 32'h80, 1'b0, 1'b0, 32'h0);
    look("alias_nt_40", 32'h40, 1'b1, 1'b0, 32'h100);
    upd(1'b1, 32'h80, 1'b1, 32'h200, 1'b0);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    look("alias_t_80", 32'h80, 1'b1, 1'b1, 32'h200);
    look("alias_t_40", 32'h40, 1'b0, 1'b0, 32'h0);

    // Reclaim index 0 for 0x40.
    upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    look("realloc_40", 32'h40, 1'b1, 1'b1, 32'h100);
    look("realloc_80", 32'h80, 1'b0, 1'b0, 32'h0);

    // Same-cycle lookup and update: old target now, new target next cycle.
    upd(1'b1, 32'h40, 1'b1, 32'h300, 1'b0);
    look("same_pre", 32'h40, 1'b1, 1'b1, 32'h100);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    look("same_post", 32'h40, 1'b1, 1'b1, 32'h300);
    look("lowbits_43", 32'h43, 1'b1, 1'b1, 32'h300);

    // A second index is independent of index 0.
    upd(1'b1, 32'h44, 1'b1, 32'h500, 1'b0);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    look("idx1_44", 32'h44, 1'b1, 1'b1, 32'h500);
    look("idx1_40", 32'h40, 1'b1, 1'b1, 32'h300);

    // Reset with a concurrent update: the update is dropped, all miss.
    rst = 1'b1;
    upd(1'b1, 32'h48, 1'b1, 32'h600, 1'b1);
    tick();
    rst = 1'b0;
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    look("rst2_48", 32'h48, 1'b0, 1'b0, 32'h0);
    look("rst2_40", 32'h40, 1'b0, 1'b0, 32'h0);
    look("rst2_44", 32'h44, 1'b0, 1'b0, 32'h0);
    look("rst2_80", 32'h80, 1'b0, 1'b0, 32'h0);
    chk("rst2_stat_br", bp_if.stat_branches, 32'h0);

    // Not-taken miss never allocates.
    upd(1'b1, 32'h40, 1'b0, 32'h700, 1'b0);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    look("nt_miss_40", 32'h40, 1'b0, 1'b0, 32'h0);

    // Statistics: clear, then five updates with two mispredicts.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b1);
    tick();
    upd(1'b1, 32'h44, 1'b0, 32'h0,   1'b0);
    tick();
    upd(1'b1, 32'h48, 1'b1, 32'h120, 1'b1);
    tick();
    upd(1'b1, 32'h40, 1'b0, 32'h0,   1'b0);
    tick();
    upd(1'b1, 32'h4C, 1'b1, 32'h140, 1'b0);
    tick();
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("stat_br", bp_if.stat_branches, EXP_BRANCHES);
    chk("stat_mp", bp_if.stat_mispredicts, EXP_MISPREDICTS);
    tick();
    chk("stat_br_idle", bp_if.stat_branches, EXP_BRANCHES);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("stat_br_rst", bp_if.stat_branches, 32'h0);
    chk("stat_mp_rst", bp_if.stat_mispredicts, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Branch target buffer with 2-bit saturating direction counters.
- Answers the fetch stage's per-cycle prediction lookup by supplying predict_taken, predict_target and predict_valid for the current PC.
- Trained by resolved branches coming back from execute.
- Lookup is combinational from registered table state; training is sequential.

Parameters:
- DATA_WIDTH, 32, address/target width.
- BTB_ENTRIES, 16, number of direct-mapped entries; power of two, at least 2.
- IDX_W, $clog2(BTB_ENTRIES), index width; derived, not overridden.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- pc_fetch  input  DATA_WIDTH  PC being fetched this cycle (lookup address).
- predict_valid  output  1  BTB hit for pc_fetch.
- predict_taken  output  1  hit and counter predicts taken.
- predict_target  output  DATA_WIDTH  stored target on hit, else 0.
- update_en  input  1  resolved branch/jump this cycle.
- update_pc  input  DATA_WIDTH  PC of resolved instruction.
- update_taken  input  1  actual outcome.
- update_target  input  DATA_WIDTH  actual target (PC_target).
- update_mispredict  input  1  execute detected a misprediction; used only by stats.
- stat_branches  output  32  resolved-branch count (BP_STATS_EN).
- stat_mispredicts  output  32  mispredict count (BP_STATS_EN).

Behaviour:
- Address split:
  - index = pc[IDX_W+1:2]
  - tag = pc[DATA_WIDTH-1:IDX_W+2]
  - pc[1:0] ignored.
- Entry state: valid (1), tag, target (DATA_WIDTH), ctr (2).
- Lookup is pure combinational on registered state, with no internal bypass:
  - predict_valid = valid[idx] && tag[idx]==tag(pc_fetch).
  - predict_taken = predict_valid && ctr[idx][1].
  - predict_target = predict_valid ? target[idx] : 0.
- Update on posedge clk when update_en && !rst, at index/tag of update_pc:
  - Hit, taken:
    - ctr = min(ctr+1, 3).
    - target = update_target.
  - Hit, not taken:
    - ctr = max(ctr-1, 0).
    - target unchanged.
  - Miss, taken: allocate/replace the entry.
    - valid=1, tag written, target = update_target, ctr = 2'b10 (weakly taken).
  - Miss, not taken: no change.
    - No allocation.
    - A conflicting valid entry is left intact.
- Counter saturates: 3 stays 3 on taken; 0 stays 0 on not-taken. No wrap.
- Same-cycle lookup and update to the same entry: outputs reflect pre-update state that cycle; new state is visible from the next cycle.
- Only one update port, so there are no update collisions. Fetch stall (PC_en low) does not affect the predictor.
- Reset, synchronous, applies from any state including mid-training:
  - All valid=0, ctr=2'b01, target=0, tag=0.
  - update_en during a reset cycle is ignored.
  - After reset all three predict outputs are 0 for any pc_fetch.
- Only valid bits and counters need reset logic semantically, but all fields reset for deterministic simulation.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - stat_branches increments on each update_en cycle.
  - stat_mispredicts increments on update_en && update_mispredict.
  - Both are 32-bit wrapping, reset to 0 by rst, and registered (visible the cycle after the event).
- Undefined:
  - Both outputs tied to 0, no counter flops.
  - update_mispredict unused; lint waiver.

Test Plan:
- Reset, then pc_fetch=0x40 -> predict_valid=0, predict_taken=0, predict_target=0.
- Update pc=0x40 taken target=0x100; next cycle pc_fetch=0x40 -> valid=1, taken=1, target=0x100 (ctr=2).
- Train 0x40 with two not-taken, then one more not-taken:
  - ctr goes 2→1→0 then holds at 0; taken=0, valid=1, target still 0x100.
  - One taken: ctr=1, taken=0. A second taken: ctr=2, taken=1.
  - Three taken from ctr=2: ctr holds at 3.
- Alias case, BTB_ENTRIES=16: pc 0x80 shares index 0 with 0x40, tag differs.
  - Lookup 0x80 -> valid=0.
  - Not-taken update at 0x80 -> 0x40 entry unchanged.
  - Taken update at 0x80, target 0x200 -> lookup 0x80 hits with 0x200; lookup 0x40 now valid=0.
- Same cycle: pc_fetch=0x40 and a taken update to 0x40 with target 0x300 on a hit.
  - That cycle target=0x100.
  - Next cycle target=0x300.
  - Assert rst mid-sequence with update_en=1 -> update dropped; all lookups miss afterwards.
- With BP_STATS_EN: 5 updates, 2 with update_mispredict=1 -> stat_branches=5, stat_mispredicts=2 one cycle after the last update; rst -> both 0.
  - Without the macro, both read 0 throughout.
